// File: rtl/rr_prio_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rr_prio_arbiter_pkg
// Shared definitions for the round-robin arbiter slice: FSM state encoding and
// the default requester count / index width.
// No ports (package).
// -----------------------------------------------------------------------------
package rr_prio_arbiter_pkg;

    // Default geometry: M requesters, N = log2(M) index bits.
    localparam int M_DEFAULT = 8;
    localparam int N_DEFAULT = 3;

    // Arbiter FSM states.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

endpackage : rr_prio_arbiter_pkg

// File: rtl/rr_prio_arbiter_if.sv
// -----------------------------------------------------------------------------
// rr_prio_arbiter_if
// Request/grant bundle between the requesting blocks and the arbiter.
//   req    [M-1:0]  request vector, bit i = requester i wants the resource
//   done            current holder releases the resource this cycle
//   gnt    [M-1:0]  registered one-hot grant, zero when idle
//   gnt_id [N-1:0]  registered index of the granted requester
//   busy            high while a grant is held (== |gnt)
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface rr_prio_arbiter_if
    import rr_prio_arbiter_pkg::*;
#(
    parameter int M = M_DEFAULT,
    parameter int N = N_DEFAULT
);

    logic [M-1:0] req;
    logic         done;
    logic [M-1:0] gnt;
    logic [N-1:0] gnt_id;
    logic         busy;

    modport master (
        output req,
        output done,
        input  gnt,
        input  gnt_id,
        input  busy
    );

    modport slave (
        input  req,
        input  done,
        output gnt,
        output gnt_id,
        output busy
    );

endinterface : rr_prio_arbiter_if

// File: rtl/rr_prio_pick.sv
// -----------------------------------------------------------------------------
// rr_prio_pick
// Combinational lowest-index priority encoder.
//   vec_i   [M-1:0]  input vector
//   idx_o   [N-1:0]  index of the lowest set bit of vec_i (0 when vec_i == 0)
//   valid_o          |vec_i
// -----------------------------------------------------------------------------
module rr_prio_pick
    import rr_prio_arbiter_pkg::*;
#(
    parameter int M = M_DEFAULT,
    parameter int N = N_DEFAULT
) (
    input  logic [M-1:0] vec_i,
    output logic [N-1:0] idx_o,
    output logic         valid_o
);

    // Scanning from the top down lets the lowest set bit overwrite last.
    always_comb begin
        idx_o = '0;
        for (int i = M - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = i[N-1:0];
            end
        end
    end

    assign valid_o = |vec_i;

endmodule : rr_prio_pick

// File: rtl/rr_prio_arbiter.sv
// -----------------------------------------------------------------------------
// rr_prio_arbiter
// Round-robin arbiter sharing one resource among M requesters (M == 2**N).
// A rotating pointer masks off requesters below it; the lowest masked request
// wins, falling back to the lowest raw request when the masked set is empty.
// A grant is held until the holder asserts done or drops its request; the
// release always passes through IDLE, so consecutive grants are separated by
// exactly one idle cycle.
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    rr_prio_arbiter_if.slave (req, done in; gnt, gnt_id, busy out)
// -----------------------------------------------------------------------------
module rr_prio_arbiter
    import rr_prio_arbiter_pkg::*;
#(
    parameter int M = M_DEFAULT,
    parameter int N = N_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rr_prio_arbiter_if.slave      bus
);

    localparam logic [M-1:0] ALL_ONES = '1;
    localparam logic [M-1:0] ONE_HOT0 = M'(1);

    state_e       state_q, state_d;
    logic [M-1:0] gnt_q,   gnt_d;
    logic [N-1:0] gnt_id_q, gnt_id_d;
    logic [N-1:0] ptr_q,   ptr_d;

    logic [M-1:0] masked;
    logic [N-1:0] masked_idx, raw_idx, winner;
    logic         masked_vld, raw_vld;

    // Requesters at or above the pointer get first chance.
    assign masked = bus.req & (ALL_ONES << ptr_q);

    rr_prio_pick #(.M(M), .N(N)) u_pick_masked (
        .vec_i   (masked),
        .idx_o   (masked_idx),
        .valid_o (masked_vld)
    );

    rr_prio_pick #(.M(M), .N(N)) u_pick_raw (
        .vec_i   (bus.req),
        .idx_o   (raw_idx),
        .valid_o (raw_vld)
    );

    assign winner = masked_vld ? masked_idx : raw_idx;

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        ptr_d    = ptr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (raw_vld) begin
                    gnt_d    = ONE_HOT0 << winner;
                    gnt_id_d = winner;
                    state_d  = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // Other requesters are ignored; only the holder's own request
                // and done can end the grant. gnt_id is left as-is on release.
                if (bus.done || !bus.req[gnt_id_q]) begin
                    gnt_d   = '0;
                    // M == 2**N, so N-bit overflow is exactly the wrap to 0.
                    ptr_d   = gnt_id_q + N'(1);
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            ptr_q    <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            ptr_q    <= ptr_d;
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.gnt_id = gnt_id_q;
    assign bus.busy   = |gnt_q;

endmodule : rr_prio_arbiter

// File: tb/tb_rr_prio_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_prio_arbiter
// Directed scenarios followed by a randomized phase, all compared against a
// behavioural model that picks the first requester found when scanning
// cyclically upward from the pointer.
// -----------------------------------------------------------------------------
module tb_rr_prio_arbiter;

    localparam int M = 8;
    localparam int N = 3;

    logic clk;
    logic rst_n;

    rr_prio_arbiter_if #(.M(M), .N(N)) bus ();

    rr_prio_arbiter #(.M(M), .N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model state.
    bit m_busy;
    int m_id;
    int m_ptr;

    // Fairness bookkeeping driven by observed DUT grants.
    int waits [M];
    bit prev_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [M-1:0] r, input int p);
        for (int k = 0; k < M; k++) begin
            int idx;
            idx = (p + k) % M;
            if (r[idx]) return idx;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_busy    = 1'b0;
        m_id      = 0;
        m_ptr     = 0;
        prev_busy = 1'b0;
        for (int i = 0; i < M; i++) waits[i] = 0;
    endtask

    task automatic check_all(input string tag);
        logic [M-1:0] exp_gnt;
        exp_gnt = m_busy ? (M'(1) << m_id) : '0;
        chk({tag, "_gnt"},    32'(bus.gnt),    32'(exp_gnt));
        chk({tag, "_gnt_id"}, 32'(bus.gnt_id), 32'(m_id));
        chk({tag, "_busy"},   32'(bus.busy),   32'(m_busy));
        chk({tag, "_onehot0"}, 32'($onehot0(bus.gnt)), 32'd1);
        chk({tag, "_gnt_at_id"}, 32'(bus.gnt[bus.gnt_id]), 32'(bus.busy));
    endtask

    // One clock: model advances on the inputs present at the edge.
    task automatic tick(input string tag);
        logic [M-1:0] r;
        logic         d;
        int           maxw;
        r = bus.req;
        d = bus.done;
        @(posedge clk);
        #1;
        if (!m_busy) begin
            if (r != '0) begin
                m_id   = pick(r, m_ptr);
                m_busy = 1'b1;
            end
        end else if (d || !r[m_id]) begin
            m_busy = 1'b0;
            m_ptr  = (m_id + 1) % M;
        end
        for (int i = 0; i < M; i++) if (!r[i]) waits[i] = 0;
        if (bus.busy && !prev_busy) begin
            maxw = 0;
            for (int i = 0; i < M; i++) begin
                if (i == int'(bus.gnt_id)) waits[i] = 0;
                else if (r[i]) waits[i]++;
                if (waits[i] > maxw) maxw = waits[i];
            end
            chk({tag, "_starve"}, 32'(maxw <= M), 32'd1);
        end
        prev_busy = bus.busy;
        check_all(tag);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        chk({tag, "_gnt"},    32'(bus.gnt),    32'd0);
        chk({tag, "_busy"},   32'(bus.busy),   32'd0);
        chk({tag, "_gnt_id"}, 32'(bus.gnt_id), 32'd0);
        model_reset();
        #1;
        rst_n = 1'b1;
    endtask

    int seq [5] = '{0, 2, 7, 0, 2};

    initial begin
        model_reset();
        rst_n    = 1'b0;
        bus.req  = 8'hFF;
        bus.done = 1'b0;

        // Reset holds outputs low with no clock edge yet.
        #3;
        chk("rst_gnt",    32'(bus.gnt),    32'd0);
        chk("rst_gnt_id", 32'(bus.gnt_id), 32'd0);
        chk("rst_busy",   32'(bus.busy),   32'd0);
        #1;
        rst_n = 1'b1;
        tick("first");
        chk("first_id", 32'(bus.gnt_id), 32'd0);
        chk("first_gnt", 32'(bus.gnt), 32'h01);

        // Single request and done pulse.
        bus.req = 8'b0000_0001;
        tick("single_hold");
        chk("single_gnt", 32'(bus.gnt), 32'h01);
        bus.done = 1'b1;
        tick("single_rel");
        chk("single_rel_busy", 32'(bus.busy), 32'd0);
        bus.done = 1'b0;
        bus.req  = '0;
        tick("single_idle");

        // Fairness from ptr = 0.
        async_reset("fair_rst");
        bus.req = 8'b1000_0101;
        for (int k = 0; k < 5; k++) begin
            bus.done = 1'b0;
            tick("fair_grant");
            chk("fair_id",   32'(bus.gnt_id), 32'(seq[k]));
            chk("fair_busy", 32'(bus.busy),   32'd1);
            bus.done = 1'b1;
            tick("fair_bubble");
            chk("fair_idle", 32'(bus.busy), 32'd0);
        end
        bus.done = 1'b0;
        bus.req  = '0;

        // Wrap-around: grant 6, release to ptr 7, fallback to 0, then 1.
        bus.req = 8'b0100_0000;
        tick("wrap_g6");
        chk("wrap_id6", 32'(bus.gnt_id), 32'd6);
        bus.done = 1'b1;
        tick("wrap_rel6");
        bus.done = 1'b0;
        bus.req  = 8'b0000_0011;
        tick("wrap_g0");
        chk("wrap_id0", 32'(bus.gnt_id), 32'd0);
        bus.done = 1'b1;
        tick("wrap_rel0");
        bus.done = 1'b0;
        tick("wrap_g1");
        chk("wrap_id1", 32'(bus.gnt_id), 32'd1);
        bus.done = 1'b1;
        tick("wrap_rel1");
        bus.done = 1'b0;
        bus.req  = '0;
        tick("wrap_idle");

        // Release by dropping the holder's request.
        bus.req = 8'b0000_1000;
        tick("drop_g3");
        chk("drop_gnt3", 32'(bus.gnt), 32'h08);
        bus.req = 8'b0010_1000;
        tick("drop_hold");
        chk("drop_hold_gnt", 32'(bus.gnt), 32'h08);
        bus.req = 8'b0010_0000;
        tick("drop_rel");
        chk("drop_rel_gnt", 32'(bus.gnt), 32'h00);
        tick("drop_g5");
        chk("drop_gnt5", 32'(bus.gnt), 32'h20);
        chk("drop_id5",  32'(bus.gnt_id), 32'd5);
        bus.done = 1'b1;
        tick("drop_rel5");
        bus.done = 1'b0;

        // Async reset mid-grant, then pointer restarts at 0.
        bus.req = 8'b0001_0000;
        tick("ar_g4");
        chk("ar_id4", 32'(bus.gnt_id), 32'd4);
        async_reset("ar_mid");
        bus.req = 8'b0001_0001;
        tick("ar_g0");
        chk("ar_id0", 32'(bus.gnt_id), 32'd0);
        bus.done = 1'b1;
        tick("ar_rel0");
        bus.done = 1'b0;
        tick("ar_g4b");
        chk("ar_id4b", 32'(bus.gnt_id), 32'd4);
        bus.done = 1'b1;
        tick("ar_rel4");
        bus.done = 1'b0;

        // Randomized traffic with occasional mid-run resets.
        bus.req = M'($urandom);
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 7) == 0) bus.req = M'($urandom);
            bus.done = ($urandom_range(0, 3) == 0);
            if (c % 150 == 149) async_reset("rnd_rst");
            tick("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_rr_prio_arbiter

// File: doc/rr_prio_arbiter.md
Name: rr_prio_arbiter

Overview:
- Round-robin arbiter that shares one resource among M requesters, with a registered request/grant handshake.
- Built on the lowest-index priority encoding used by the encoder library. A rotating pointer masks the request vector so that every requester is eventually served.
- Sits between the requesting blocks and the shared resource. Drives a one-hot grant, an encoded grant index and a busy flag.

Parameters:
- M, 8, number of requesters; must satisfy M == 2**N and M >= 2.
- N, 3, width of the encoded index, log2(M).

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  M  request vector; bit i high means requester i wants the resource.
- done  input  1  the current holder releases the resource this cycle.
- gnt  output  M  one-hot grant, registered; all zero when idle.
- gnt_id  output  N  encoded index of the granted requester, registered.
- busy  output  1  high while a grant is held; equals |gnt.

Behaviour:
- Reset: rst_n low clears all state immediately, with no clock edge needed:
  - state=IDLE, gnt=0, gnt_id=0, busy=0, ptr=0.
  - Reset asserted mid-grant drops gnt at once.
- Internal pointer: ptr, N bits. Pick rule:
  - masked = req & (all ones << ptr).
  - If masked != 0, the winner is the lowest set index of masked.
  - Otherwise the winner is the lowest set index of req.
- State machine, two states: IDLE, GRANT.
- IDLE:
  - If req != 0, on the next edge: gnt = one-hot(winner), gnt_id = winner, busy = 1, go to GRANT.
  - Latency is 1 cycle from req sampled to gnt visible.
  - If req == 0, stay in IDLE with outputs at zero.
- GRANT:
  - gnt and gnt_id hold constant.
  - Changes on req bits other than req[gnt_id] are ignored.
  - Release condition: done == 1, or req[gnt_id] == 0.
  - On release, at the next edge: gnt = 0, busy = 0, ptr = gnt_id + 1 mod M (wraps from M-1 to 0), go to IDLE.
  - gnt_id keeps its last value after release.
- Bubble: exactly one idle cycle separates consecutive grants, even when requests are continuously pending.
- Simultaneous release and new requests: the release edge always lands in IDLE. The new requests are arbitrated on the following edge using the updated ptr.
- done asserted while in IDLE: ignored.
- A requester that drops req while waiting simply is not picked; no memory of past requests is kept.
- Invariants, checked by assertions in the bench:
  - gnt is zero or one-hot.
  - gnt[gnt_id] == busy.
  - No requester waits more than M grants while holding req high.

Decomposition:
- Shared include file rr_arb_defs.vh holds:
  - State encoding constants ST_IDLE=1'b0 and ST_GRANT=1'b1.
  - Default M/N values.
- One combinational sub-module, rr_prio_pick, parameterised by M and N:
  - Input: vec[M-1:0]. Outputs: idx[N-1:0] (lowest set bit) and valid (|vec).
  - Instantiated twice in rr_prio_arbiter: once on the masked vector, once on the raw req vector.
- The top level contains the mask generation, pointer register, FSM and output registers.

Test Plan:
- Reset: rst_n=0 with req=8'hFF -> gnt=8'h00, gnt_id=0, busy=0, with no clock edge needed; release reset -> first grant to index 0 one cycle after the first edge.
- Single request: req=8'b0000_0001 -> next cycle gnt=8'b0000_0001, gnt_id=0, busy=1. Pulse done -> next cycle gnt=0, busy=0, internal ptr=1.
- Fairness: req=8'b1000_0101 held, with done pulsed one cycle after each grant -> gnt_id sequence 0, 2, 7, 0, 2. Each grant is separated by exactly one idle cycle.
- Wrap-around: grant index 6 and release (ptr=7), then req=8'b0000_0011 -> grant 0 via the unmasked fallback. After release (ptr=1) -> grant 1.
- Release by request drop: hold grant on 3 (req=8'b0000_1000). Raise req[5] during the grant -> gnt stays 8'b0000_1000. Drop req[3] with done=0 -> next cycle gnt=0. Next edge -> gnt=8'b0010_0000, gnt_id=5.
- Async reset mid-grant: grant on 4, then pulse rst_n low between clock edges -> gnt=0 and busy=0 immediately. After reset, req=8'b0001_0001 -> grant 0, because ptr was reset to 0.
